button_conditioner: RTL and testbench

Front-end conditioner for the five board push-buttons (L, R, U, D, C). It synchronises and debounces each raw input, then emits the single-clock-cycle pulses the game controller consumes (Lbtn, Rbtn, Ubtn, Dbtn, Cbtn). It sits between the board pins and the tic-tac-toe FSM. Cursor-move buttons can optionally auto-repeat while held.

---
 rtl/button_conditioner_pkg.sv | 27 ++
 rtl/btn_debounce_pulse.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 56 +++++
 tb/tb_button_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-button FSM encoding,
// button bit positions in the {L,R,U,D,C} vectors, and counter sizing.
package button_conditioner_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_WQ    = 5'b00010,
      ST_PULSE = 5'b00100,
      ST_HOLD  = 5'b01000,
      ST_WR    = 5'b10000
   } btn_state_t;

   localparam int NUM_BTNS = 5;
   localparam int BTN_L    = 4;
   localparam int BTN_R    = 3;
   localparam int BTN_U    = 2;
   localparam int BTN_D    = 1;
   localparam int BTN_C    = 0;

   // Counter must hold values up to max(deb, rep)-1; never narrower than 1 bit.
   function automatic int cnt_width(input int deb, input int rep);
      int m;
      m = (deb > rep) ? deb : rep;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// One button path: 2-flop synchroniser, shared debounce/repeat counter and a
// Moore FSM producing a one-cycle press pulse plus the debounced level.
module btn_debounce_pulse
   import button_conditioner_pkg::*;
#(
   parameter int DEB_CYCLES    = 500000,
   parameter int REPEAT_CYCLES = 25000000,
   parameter bit REPEAT_EN     = 1'b0
) (
   input  logic Clk,
   input  logic Reset,
   input  logic btn,
   output logic pulse,
   output logic level
);

   localparam int CW = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   btn_state_t    state;
   logic [CW-1:0] cnt;

   // synchroniser stage
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
      end
   end

   // FSM stage: pulse/level are registered alongside the state they decode
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               pulse <= 1'b0;
               level <= 1'b0;
               if (sync_p1) begin
                  state <= ST_WQ;
                  cnt   <= '0;
               end
            end
            ST_WQ: begin
               if (!sync_p1) begin
                  state <= ST_IDLE;
                  pulse <= 1'b0;
                  level <= 1'b0;
               end else if (cnt == DEB_LAST) begin
                  state <= ST_PULSE;
                  pulse <= 1'b1;
                  level <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  pulse <= 1'b0;
                  level <= 1'b0;
               end
            end
            ST_PULSE: begin
               state <= ST_HOLD;
               cnt   <= '0;
               pulse <= 1'b0;
               level <= 1'b1;
            end
            ST_HOLD: begin
               level <= 1'b1;
               pulse <= 1'b0;
               if (!sync_p1) begin
                  state <= ST_WR;
                  cnt   <= '0;
               end else if (REPEAT_EN) begin
                  if (cnt == REP_LAST) begin
                     state <= ST_PULSE;
                     pulse <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            ST_WR: begin
               pulse <= 1'b0;
               if (sync_p1) begin
                  // Release glitch: back to HOLD without a new pulse
                  state <= ST_HOLD;
                  cnt   <= '0;
                  level <= 1'b1;
               end else if (cnt == DEB_LAST) begin
                  state <= ST_IDLE;
                  level <= 1'b0;
               end else begin
                  cnt   <= cnt + 1'b1;
                  level <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               pulse <= 1'b0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Five independent button conditioners between the board pins and the game
// FSM; REPEAT_MASK ({L,R,U,D,C}) selects which buttons auto-repeat.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int         DEB_CYCLES    = 500000,
   parameter int         REPEAT_CYCLES = 25000000,
   parameter logic [4:0] REPEAT_MASK   = 5'b01010
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       BtnL,
   input  logic       BtnR,
   input  logic       BtnU,
   input  logic       BtnD,
   input  logic       BtnC,
   output logic       Lbtn,
   output logic       Rbtn,
   output logic       Ubtn,
   output logic       Dbtn,
   output logic       Cbtn,
   output logic [4:0] Levels
);

   logic [NUM_BTNS-1:0] raw;
   logic [NUM_BTNS-1:0] pulses;
   logic [NUM_BTNS-1:0] levels;

   assign raw[BTN_L] = BtnL;
   assign raw[BTN_R] = BtnR;
   assign raw[BTN_U] = BtnU;
   assign raw[BTN_D] = BtnD;
   assign raw[BTN_C] = BtnC;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce_pulse #(
         .DEB_CYCLES   (DEB_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .REPEAT_EN    (REPEAT_MASK[i])
      ) u_btn (
         .Clk  (Clk),
         .Reset(Reset),
         .btn  (raw[i]),
         .pulse(pulses[i]),
         .level(levels[i])
      );
   end

   assign Lbtn   = pulses[BTN_L];
   assign Rbtn   = pulses[BTN_R];
   assign Ubtn   = pulses[BTN_U];
   assign Dbtn   = pulses[BTN_D];
   assign Cbtn   = pulses[BTN_C];
   assign Levels = levels;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing input,
// all cycles compared against a run-length reference model of each button.
module tb_button_conditioner;

   localparam int         DEB  = 4;
   localparam int         REP  = 10;
   localparam logic [4:0] MASK = 5'b01010;

   logic       Clk;
   logic       Reset;
   logic [4:0] raw;
   logic       Lbtn, Rbtn, Ubtn, Dbtn, Cbtn;
   logic [4:0] Levels;
   logic [4:0] pv;

   button_conditioner #(
      .DEB_CYCLES   (DEB),
      .REPEAT_CYCLES(REP),
      .REPEAT_MASK  (MASK)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .BtnL  (raw[4]),
      .BtnR  (raw[3]),
      .BtnU  (raw[2]),
      .BtnD  (raw[1]),
      .BtnC  (raw[0]),
      .Lbtn  (Lbtn),
      .Rbtn  (Rbtn),
      .Ubtn  (Ubtn),
      .Dbtn  (Dbtn),
      .Cbtn  (Cbtn),
      .Levels(Levels)
   );

   assign pv = {Lbtn, Rbtn, Ubtn, Dbtn, Cbtn};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: raw delayed two edges, then runs of equal samples
   bit m_s1 [5];
   bit m_s2 [5];
   bit m_pressed [5];
   bit m_pulse [5];
   int m_ones [5];
   int m_zeros [5];
   int m_age [5];

   int pq [5][$];
   int lfall [5];
   bit prev_lvl [5];
   int lmax_c;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 5; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_pressed[i] = 0; m_pulse[i] = 0;
         m_ones[i] = 0; m_zeros[i] = 0; m_age[i] = 0; prev_lvl[i] = 0;
      end
   endtask

   task automatic model_step();
      bit y;
      for (int i = 0; i < 5; i++) begin
         y = m_s2[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
         if (m_pulse[i]) begin
            m_pulse[i] = 0; m_age[i] = 0; m_zeros[i] = 0;
         end else if (!m_pressed[i]) begin
            m_ones[i] = y ? m_ones[i] + 1 : 0;
            if (m_ones[i] == DEB + 1) begin
               m_pulse[i] = 1; m_pressed[i] = 1; m_ones[i] = 0;
            end
         end else if (!y) begin
            m_zeros[i]++; m_age[i] = 0;
            if (m_zeros[i] == DEB + 1) begin
               m_pressed[i] = 0; m_zeros[i] = 0; m_ones[i] = 0;
            end
         end else if (m_zeros[i] > 0) begin
            m_zeros[i] = 0; m_age[i] = 0;
         end else begin
            m_age[i]++;
            if (MASK[i] && m_age[i] == REP) m_pulse[i] = 1;
         end
      end
   endtask

   task automatic tick();
      logic [9:0] expv;
      @(posedge Clk);
      cyc++;
      model_step();
      #1;
      for (int i = 0; i < 5; i++) begin
         expv[5+i] = m_pulse[i];
         expv[i]   = m_pressed[i];
         if (pv[i]) pq[i].push_back(cyc);
         if (prev_lvl[i] && !Levels[i]) lfall[i] = cyc;
         prev_lvl[i] = Levels[i];
      end
      if (Levels[0]) lmax_c = 1;
      check("outputs", {22'd0, pv, Levels}, {22'd0, expv});
   endtask

   task automatic clear_rec();
      for (int i = 0; i < 5; i++) begin
         pq[i].delete();
         lfall[i] = -1;
      end
   endtask

   task automatic ticks(input int n);
      for (int t = 0; t < n; t++) tick();
   endtask

   int k, j;

   initial begin
      Reset = 1'b1;
      raw   = 5'b0;
      model_clear();
      clear_rec();
      repeat (3) @(posedge Clk);
      #3;
      check("reset_state", {22'd0, pv, Levels}, 32'd0);
      Reset = 1'b0;
      ticks(5);

      // clean press on U (no repeat)
      clear_rec();
      raw[2] = 1'b1; k = cyc + 1;
      ticks(20);
      check("u_pulse_count", pq[2].size(), 1);
      if (pq[2].size() >= 1) check("u_pulse_time", pq[2][0], k + DEB + 2);
      check("u_level_held", {31'd0, Levels[2]}, 1);
      raw[2] = 1'b0; j = cyc + 1;
      ticks(12);
      // IDLE is reached on the (DEB+3)th edge counting the capture edge itself
      check("u_release_time", lfall[2], j + DEB + 2);

      // bounce on C: 3-high / 1-low
      clear_rec(); lmax_c = 0;
      for (int t = 0; t < 30; t++) begin
         raw[0] = ((t % 4) != 3);
         tick();
      end
      raw[0] = 1'b0;
      ticks(8);
      check("c_bounce_pulses", pq[0].size(), 0);
      check("c_bounce_level", lmax_c, 0);

      // auto-repeat on R, single pulse on U over the same hold
      clear_rec();
      raw[3] = 1'b1; raw[2] = 1'b1; k = cyc + 1;
      ticks(40);
      raw[3] = 1'b0; raw[2] = 1'b0;
      ticks(12);
      check("r_repeat_count", pq[3].size(), 4);
      if (pq[3].size() == 4)
         for (int p = 0; p < 4; p++)
            check("r_repeat_time", pq[3][p], k + DEB + 2 + p * (REP + 1));
      check("u_hold_count", pq[2].size(), 1);

      // release glitch on D
      clear_rec();
      raw[1] = 1'b1;
      ticks(8);
      raw[1] = 1'b0; ticks(2);
      raw[1] = 1'b1; ticks(1);
      raw[1] = 1'b0; j = cyc + 1;
      ticks(12);
      check("d_glitch_pulses", pq[1].size(), 1);
      check("d_glitch_release", lfall[1], j + DEB + 2);

      // simultaneous L and D
      clear_rec();
      raw[4] = 1'b1; raw[1] = 1'b1; k = cyc + 1;
      ticks(9);
      raw[4] = 1'b0; raw[1] = 1'b0;
      ticks(12);
      check("l_sim_count", pq[4].size(), 1);
      check("d_sim_count", pq[1].size(), 1);
      if (pq[4].size() >= 1) check("l_sim_time", pq[4][0], k + DEB + 2);
      if (pq[1].size() >= 1) check("d_sim_time", pq[1][0], k + DEB + 2);

      // reset while C qualifies and U is held
      raw[2] = 1'b1;
      ticks(10);
      raw[0] = 1'b1;
      ticks(4);
      Reset = 1'b1;
      #1;
      check("reset_mid", {22'd0, pv, Levels}, 32'd0);
      model_clear();
      repeat (2) @(posedge Clk);
      #3;
      Reset = 1'b0;
      clear_rec();
      k = cyc + 1;
      ticks(12);
      check("c_after_reset_count", pq[0].size(), 1);
      if (pq[0].size() >= 1) check("c_after_reset_time", pq[0][0], k + DEB + 2);
      check("u_after_reset_count", pq[2].size(), 1);
      raw = 5'b0;
      ticks(12);

      // random bouncing on all buttons, varying toggle rates
      for (int seg = 0; seg < 40; seg++) begin
         int div;
         div = (($urandom_range(0, 2)) == 0) ? 3 : (($urandom_range(0, 1) == 0) ? 12 : 40);
         for (int t = 0; t < 100; t++) begin
            for (int i = 0; i < 5; i++)
               if ($urandom_range(0, div - 1) == 0) raw[i] = ~raw[i];
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
